// File: rtl/core_dispatcher_if.sv
// Host/core-side bundle for core_dispatcher: launch request, per-core
// completion flags, per-core status codes and run results.
interface core_dispatcher_if #(
  parameter int NUM_CORES = 4,
  parameter int CYCLE_W   = 16
);
  logic                   start;
  logic [NUM_CORES-1:0]   core_mask;
  logic [NUM_CORES-1:0]   end_process;
  logic [2*NUM_CORES-1:0] status;
  logic                   busy;
  logic                   done;
  logic                   timeout;
  logic [NUM_CORES-1:0]   finished_mask;
  logic [CYCLE_W-1:0]     cycle_count;

  modport master (
    output start, core_mask, end_process,
    input  status, busy, done, timeout, finished_mask, cycle_count
  );

  modport slave (
    input  start, core_mask, end_process,
    output status, busy, done, timeout, finished_mask, cycle_count
  );
endinterface

// File: rtl/core_dispatcher.sv
// Launches the selected matrix-multiplier cores, tracks each to completion
// and reports done/timeout plus the number of RUN cycles spent.
module core_dispatcher #(
  parameter int NUM_CORES  = 4,
  parameter int CYCLE_W    = 16,
  parameter int MAX_CYCLES = 4000
) (
  input  logic              clock,
  input  logic              reset,
  core_dispatcher_if.slave  bus
);
  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_RUN, S_DONE} state_t;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_INIT = 2'b11;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_HALT = 2'b10;
  localparam logic [CYCLE_W-1:0] LAST_CYCLE = CYCLE_W'(MAX_CYCLES - 1);

  state_t                 state;
  logic [NUM_CORES-1:0]   active_mask;
  logic [NUM_CORES-1:0]   finished_mask;
  logic [NUM_CORES-1:0]   fin_next;
  logic [2*NUM_CORES-1:0] status;
  logic [2*NUM_CORES-1:0] st_init, st_go, st_run, st_halt;
  logic [CYCLE_W-1:0]     cycle_count;
  logic                   busy, done, timeout;

  // Status words are precomputed for every transition so that the registered
  // status always matches the state being entered on the same edge.
  always_comb begin
    fin_next = finished_mask | (bus.end_process & active_mask);
    st_init  = '0;
    st_go    = '0;
    st_run   = '0;
    st_halt  = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      st_init[2*i +: 2] = bus.core_mask[i] ? ST_INIT : ST_IDLE;
      st_go[2*i +: 2]   = active_mask[i] ? ST_RUN : ST_IDLE;
      st_halt[2*i +: 2] = active_mask[i] ? ST_HALT : ST_IDLE;
      st_run[2*i +: 2]  = !active_mask[i] ? ST_IDLE :
                          (fin_next[i] ? ST_HALT : ST_RUN);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= S_IDLE;
      active_mask   <= '0;
      finished_mask <= '0;
      cycle_count   <= '0;
      status        <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      timeout       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start && (bus.core_mask != '0)) begin
            state         <= S_LAUNCH;
            active_mask   <= bus.core_mask;
            finished_mask <= '0;
            cycle_count   <= '0;
            timeout       <= 1'b0;
            status        <= st_init;
            busy          <= 1'b1;
          end
        end
        S_LAUNCH: begin
          state  <= S_RUN;
          status <= st_go;
        end
        S_RUN: begin
          finished_mask <= fin_next;
          cycle_count   <= cycle_count + 1'b1;
          if (fin_next == active_mask) begin
            state   <= S_DONE;
            status  <= st_halt;
            busy    <= 1'b0;
            done    <= 1'b1;
            timeout <= 1'b0;
          end else if (cycle_count == LAST_CYCLE) begin
            state   <= S_DONE;
            status  <= st_halt;
            busy    <= 1'b0;
            done    <= 1'b1;
            timeout <= 1'b1;
          end else begin
            status <= st_run;
          end
        end
        S_DONE: begin
          if (!bus.start) begin
            state  <= S_IDLE;
            status <= '0;
            done   <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.status        = status;
  assign bus.busy          = busy;
  assign bus.done          = done;
  assign bus.timeout       = timeout;
  assign bus.finished_mask = finished_mask;
  assign bus.cycle_count   = cycle_count;
endmodule
